lifo_stack: RTL and testbench

Parametrised last-in-first-out buffer that replaces the fixed 6-bit, 4-entry stack used on the Nexys3 data path. It adds:
- configurable width and depth
- a registered pop data path with a valid strobe
- defined simultaneous push/pop behaviour
- an occupancy count, an almost-full threshold, sticky overflow/underflow errors and a synchronous flush

It sits between the switch/button input logic and the display/consumer logic on the single system clock.

---
 rtl/lifo_pkg.sv | 27 ++
 rtl/lifo_mem.sv | 24 ++
 rtl/lifo_stack.sv | 132 +++++++++++++
 tb/tb_lifo_stack.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared types and helpers for the LIFO stack: request decode and width helper.
package lifo_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_POP, OP_PUSH, OP_BOTH} op_t;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic op_t decode_op(input logic pop, input logic push);
    op_t op;
    unique case ({pop, push})
      2'b00:   op = OP_NONE;
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      default: op = OP_BOTH;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module lifo_mem #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO with registered pop data, valid strobe, occupancy flags,
// sticky overflow/underflow errors and synchronous flush.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  localparam int unsigned CW       = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW       = clog2(DEPTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);
  localparam logic [CW-1:0] CntAf   = CW'(AF_THRESH);

  op_t              op;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             is_empty, is_full;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr, mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  assign op       = decode_op(pop, push);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CntFull);
  // Guarded so a non-power-of-two array is never read out of range when empty.
  assign mem_raddr = is_empty ? '0 : AW'(count_q - CntOne);

  always_comb begin
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q & ~clr_err;
    udf_d      = udf_q & ~clr_err;
    mem_we     = 1'b0;
    mem_waddr  = AW'(count_q);
    if (flush) begin
      count_d = '0;
    end else begin
      unique case (op)
        OP_POP: begin
          if (is_empty) begin
            udf_d = 1'b1;
          end else begin
            data_out_d = mem_rdata;
            count_d    = count_q - CntOne;
            rd_valid_d = 1'b1;
          end
        end
        OP_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CntOne;
          end
        end
        OP_BOTH: begin
          rd_valid_d = 1'b1;
          if (is_empty) begin
            data_out_d = data_in;
          end else begin
            // Replace top: old top goes out, new word takes its slot.
            data_out_d = mem_rdata;
            mem_we     = 1'b1;
            mem_waddr  = mem_raddr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  lifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(data_in),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign data_out    = data_out_q;
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= CntAf);
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: default 6x4 instance and an 8x5 (AF_THRESH=3) instance driven in lockstep.
module tb_lifo_stack;

  logic       clk, rst_n, flush, push, pop, clr_err;
  logic [7:0] din;

  logic [5:0] d1_dout;
  logic [2:0] d1_count;
  logic       d1_rv, d1_empty, d1_full, d1_af, d1_ovf, d1_udf;
  logic [7:0] d2_dout;
  logic [2:0] d2_count;
  logic       d2_rv, d2_empty, d2_full, d2_af, d2_ovf, d2_udf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-instance stack image, occupancy and sticky flags.
  logic [7:0] stk [2][8];
  int         cnt [2];
  logic       ovf [2];
  logic       udf [2];
  logic       exp_v [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  lifo_stack u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop), .clr_err(clr_err),
    .data_in(din[5:0]), .data_out(d1_dout), .rd_valid(d1_rv), .count(d1_count),
    .empty(d1_empty), .full(d1_full), .almost_full(d1_af), .overflow(d1_ovf),
    .underflow(d1_udf)
  );

  lifo_stack #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop), .clr_err(clr_err),
    .data_in(din), .data_out(d2_dout), .rd_valid(d2_rv), .count(d2_count),
    .empty(d2_empty), .full(d2_full), .almost_full(d2_af), .overflow(d2_ovf),
    .underflow(d2_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitors: every rd_valid strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && d1_rv) begin
      if (q0.size() == 0) check("d1_unexpected_rd_valid", 32'(d1_rv), 32'd0);
      else check("d1_pop_data", 32'(d1_dout), 32'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && d2_rv) begin
      if (q1.size() == 0) check("d2_unexpected_rd_valid", 32'(d2_rv), 32'd0);
      else check("d2_pop_data", 32'(d2_dout), 32'(q1.pop_front()));
    end
  end

  task automatic model(input int d, input int dep, input logic [7:0] mask);
    logic [7:0] e;
    logic       v;
    e = '0;
    v = 1'b0;
    if (clr_err) begin
      ovf[d] = 1'b0;
      udf[d] = 1'b0;
    end
    if (flush) begin
      cnt[d] = 0;
    end else if (pop && !push) begin
      if (cnt[d] == 0) udf[d] = 1'b1;
      else begin
        cnt[d]--;
        e = stk[d][cnt[d]];
        v = 1'b1;
      end
    end else if (push && !pop) begin
      if (cnt[d] == dep) ovf[d] = 1'b1;
      else begin
        stk[d][cnt[d]] = din & mask;
        cnt[d]++;
      end
    end else if (push && pop) begin
      v = 1'b1;
      if (cnt[d] == 0) e = din & mask;
      else begin
        e = stk[d][cnt[d] - 1];
        stk[d][cnt[d] - 1] = din & mask;
      end
    end
    exp_v[d] = v;
    if (v) begin
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic chk_state(input string p, input int d, input int dep, input logic [2:0] c,
                           input logic e, input logic f, input logic a, input logic o,
                           input logic u, input logic v);
    check({p, "_count"}, 32'(c), 32'(cnt[d]));
    check({p, "_empty"}, 32'(e), 32'(cnt[d] == 0));
    check({p, "_full"}, 32'(f), 32'(cnt[d] == dep));
    check({p, "_almost_full"}, 32'(a), 32'(cnt[d] >= 3));
    check({p, "_overflow"}, 32'(o), 32'(ovf[d]));
    check({p, "_underflow"}, 32'(u), 32'(udf[d]));
    check({p, "_rd_valid"}, 32'(v), 32'(exp_v[d]));
  endtask

  task automatic step(input logic f, input logic pu, input logic po, input logic ce,
                      input logic [7:0] d);
    flush = f; push = pu; pop = po; clr_err = ce; din = d;
    model(0, 4, 8'h3f);
    model(1, 5, 8'hff);
    @(posedge clk);
    #1;
    chk_state("d1", 0, 4, d1_count, d1_empty, d1_full, d1_af, d1_ovf, d1_udf, d1_rv);
    chk_state("d2", 1, 5, d2_count, d2_empty, d2_full, d2_af, d2_ovf, d2_udf, d2_rv);
    flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset();
    check("rst_d1_count", 32'(d1_count), 32'd0);
    check("rst_d1_data_out", 32'(d1_dout), 32'd0);
    check("rst_d1_rd_valid", 32'(d1_rv), 32'd0);
    check("rst_d1_flags", 32'({d1_ovf, d1_udf, d1_empty, d1_full, d1_af}), 32'b00100);
    check("rst_d2_count", 32'(d2_count), 32'd0);
    check("rst_d2_data_out", 32'(d2_dout), 32'd0);
    check("rst_d2_rd_valid", 32'(d2_rv), 32'd0);
    check("rst_d2_flags", 32'({d2_ovf, d2_udf, d2_empty, d2_full, d2_af}), 32'b00100);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      ovf[d] = 1'b0;
      udf[d] = 1'b0;
      exp_v[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  logic [7:0] seq [4];
  logic [7:0] pops [4];

  initial begin
    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
    model_reset();
    #1;
    chk_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset();

    // Underflow and sticky clear; a set in the same cycle as clr_err wins.
    step(0, 0, 1, 0, 8'h00);
    check("udf_set", 32'(d1_udf), 32'd1);
    check("udf_no_valid", 32'(d1_rv), 32'd0);
    check("udf_data_hold", 32'(d1_dout), 32'd0);
    step(0, 0, 1, 1, 8'h00);
    check("udf_set_beats_clr", 32'(d1_udf), 32'd1);
    step(0, 0, 0, 1, 8'h00);
    check("udf_cleared", 32'(d1_udf), 32'd0);

    // Fill, overflow, drain in reverse order.
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h3F;
    foreach (seq[i]) step(0, 1, 0, 0, seq[i]);
    check("fill_full", 32'(d1_full), 32'd1);
    check("fill_count", 32'(d1_count), 32'd4);
    step(0, 1, 0, 0, 8'h05);
    check("ovf_set", 32'(d1_ovf), 32'd1);
    check("ovf_count_hold", 32'(d1_count), 32'd4);
    pops[0] = 8'h3F; pops[1] = 8'h33; pops[2] = 8'h22; pops[3] = 8'h11;
    foreach (pops[i]) begin
      step(0, 0, 1, 0, 8'h00);
      check("drain_data", 32'(d1_dout), 32'(pops[i]));
      check("drain_valid", 32'(d1_rv), 32'd1);
    end
    check("drain_empty", 32'(d1_empty), 32'd1);
    step(1, 0, 0, 1, 8'h00);

    // Replace top, then pop the replacement.
    step(0, 1, 0, 0, 8'h0A);
    step(0, 1, 0, 0, 8'h0B);
    step(0, 1, 1, 0, 8'h0C);
    check("replace_data", 32'(d1_dout), 32'h0B);
    check("replace_count", 32'(d1_count), 32'd2);
    step(0, 0, 1, 0, 8'h00);
    check("replace_pop", 32'(d1_dout), 32'h0C);
    step(1, 0, 0, 0, 8'h00);

    // Pass-through on empty.
    step(0, 1, 1, 0, 8'h2A);
    check("pass_data", 32'(d1_dout), 32'h2A);
    check("pass_valid", 32'(d1_rv), 32'd1);
    check("pass_count", 32'(d1_count), 32'd0);
    check("pass_no_err", 32'({d1_ovf, d1_udf}), 32'd0);

    // Flush wins over push.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'(8'h40 + i));
    step(1, 1, 0, 0, 8'h99);
    check("flush_count", 32'(d1_count), 32'd0);
    check("flush_empty", 32'(d1_empty), 32'd1);
    check("flush_no_ovf", 32'(d1_ovf), 32'd0);

    // almost_full / full thresholds on the 8x5 instance.
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 0, 8'(8'hA0 + i));
      check("d2_af_ramp", 32'(d2_af), 32'(i >= 3));
      check("d2_full_ramp", 32'(d2_full), 32'(i == 5));
    end
    step(1, 0, 0, 1, 8'h00);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'(8'h50 + i));
    push = 1'b1;
    rst_n = 1'b0;
    #2;
    chk_reset();
    model_reset();
    push = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset();

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(31) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(15) == 0), 8'($urandom));
    end
    step(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    check("d1_scoreboard_drained", 32'(q0.size()), 32'd0);
    check("d2_scoreboard_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
